// File: rtl/bep_readout_controller_pkg.sv
// Shared constants, state encoding and status-byte helpers for the BEP readout controller.
package bep_pkg;

  localparam int NUM_BYTES = 10;
  localparam int OVR_WIDTH = 4;

  localparam logic [3:0] IDX_ROOM_LO = 4'd0;
  localparam logic [3:0] IDX_ROOM_HI = 4'd1;
  localparam logic [3:0] IDX_SET_LO  = 4'd2;
  localparam logic [3:0] IDX_SET_HI  = 4'd3;
  localparam logic [3:0] IDX_ID_0    = 4'd4;
  localparam logic [3:0] IDX_ID_1    = 4'd5;
  localparam logic [3:0] IDX_ID_2    = 4'd6;
  localparam logic [3:0] IDX_ID_3    = 4'd7;
  localparam logic [3:0] IDX_STATE   = 4'd8;
  localparam logic [3:0] IDX_STATUS  = 4'(NUM_BYTES - 1);

  localparam int STAT_STICKY_BIT = 0;
  localparam int STAT_OVR_LSB    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READY   = 2'd1,
    ST_READING = 2'd2
  } rd_state_e;

  function automatic logic [7:0] make_status(input logic [OVR_WIDTH-1:0] ovr,
                                             input logic sticky);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_OVR_LSB +: OVR_WIDTH] = ovr;
    s[STAT_STICKY_BIT] = sticky;
    return s;
  endfunction

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [OVR_WIDTH-1:0] ovr_sat_inc(input logic [OVR_WIDTH-1:0] v);
    logic [OVR_WIDTH-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + OVR_WIDTH'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bep_readout_controller_if.sv
// Bundle of decoder-side and host-side signals of the readout controller.
interface bep_readout_controller_if;

  logic        frame_valid;
  logic [15:0] room_temp;
  logic [15:0] set_temp;
  logic [31:0] thermostat_id;
  logic [7:0]  state;
  logic        rx_enable;
  logic        read_start;
  logic        byte_ack;
  logic        read_abort;
  logic        data_ready;
  logic        data_valid;
  logic [3:0]  byte_index;
  logic [7:0]  data_out;

  modport master (
    output frame_valid, room_temp, set_temp, thermostat_id, state,
    output read_start, byte_ack, read_abort,
    input  rx_enable, data_ready, data_valid, byte_index, data_out
  );

  modport slave (
    input  frame_valid, room_temp, set_temp, thermostat_id, state,
    input  read_start, byte_ack, read_abort,
    output rx_enable, data_ready, data_valid, byte_index, data_out
  );

endinterface

// File: rtl/bep_readout_controller_snapshot_mux.sv
// Frame snapshot plus status byte frozen at read start; selects one byte by index.
module bep_snapshot_mux
  import bep_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_snap_i,
  input  logic [71:0] snap_i,
  input  logic        load_status_i,
  input  logic [7:0]  status_i,
  input  logic [3:0]  index_i,
  output logic [7:0]  byte_o
);

  logic [71:0] snap_q;
  logic [7:0]  status_q;

  // Snapshot and frozen status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q   <= 72'd0;
      status_q <= 8'h00;
    end else begin
      if (load_snap_i) begin
        snap_q <= snap_i;
      end
      if (load_status_i) begin
        status_q <= status_i;
      end
    end
  end

  // Little-endian byte selection; out-of-range indices read as zero.
  always_comb begin
    byte_o = 8'h00;
    case (index_i)
      IDX_ROOM_LO: byte_o = snap_q[7:0];
      IDX_ROOM_HI: byte_o = snap_q[15:8];
      IDX_SET_LO:  byte_o = snap_q[23:16];
      IDX_SET_HI:  byte_o = snap_q[31:24];
      IDX_ID_0:    byte_o = snap_q[39:32];
      IDX_ID_1:    byte_o = snap_q[47:40];
      IDX_ID_2:    byte_o = snap_q[55:48];
      IDX_ID_3:    byte_o = snap_q[63:56];
      IDX_STATE:   byte_o = snap_q[71:64];
      IDX_STATUS:  byte_o = status_q;
      default:     byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/bep_readout_controller.sv
// Host readout sequencer for decoded BEP frames: capture, overrun counting and
// byte-wise presentation over a ready/ack handshake.
module bep_readout_controller
  import bep_pkg::*;
(
  input  logic clock,
  input  logic reset,
  bep_readout_controller_if.slave bus
);

  rd_state_e            state_q, state_d;
  logic                 valid_q;
  logic                 capture_s, last_ack_s;
  logic                 load_snap_s, freeze_s, end_read_s;
  logic [OVR_WIDTH-1:0] ovr_q, ovr_d;
  logic                 sticky_q, sticky_d;
  logic                 data_ready_q, data_ready_d;
  logic                 data_valid_q, data_valid_d;
  logic                 rx_enable_q, rx_enable_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           data_out_q, data_out_d;
  logic [7:0]           mux_byte_s;

  assign capture_s  = bus.frame_valid & ~valid_q;
  assign last_ack_s = bus.byte_ack & (idx_q == IDX_STATUS);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort has priority over ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READY: begin
        if (bus.read_start) begin
          state_d = ST_READING;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_READING: begin
        if (bus.read_abort) begin
          state_d = ST_READY;
        end else if (last_ack_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values derived from current state and strobes.
  always_comb begin
    load_snap_s = 1'b0;
    freeze_s    = 1'b0;
    end_read_s  = 1'b0;
    idx_d       = 4'd0;
    case (state_q)
      ST_IDLE: begin
        load_snap_s = capture_s;
      end
      ST_READY: begin
        // A frame arriving with read_start is dropped so the read sees a stable snapshot.
        load_snap_s = capture_s & ~bus.read_start;
        freeze_s    = bus.read_start;
      end
      ST_READING: begin
        end_read_s = ~bus.read_abort & last_ack_s;
        if (bus.read_abort | last_ack_s) begin
          idx_d = 4'd0;
        end else if (bus.byte_ack) begin
          idx_d = idx_q + 4'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        load_snap_s = 1'b0;
      end
    endcase

    if (end_read_s) begin
      ovr_d    = '0;
      sticky_d = 1'b0;
    end else if (capture_s && (state_q != ST_IDLE)) begin
      ovr_d    = ovr_sat_inc(ovr_q);
      sticky_d = 1'b1;
    end else begin
      ovr_d    = ovr_q;
      sticky_d = sticky_q;
    end

    data_ready_d = (state_d != ST_IDLE);
    data_valid_d = (state_d == ST_READING);
    rx_enable_d  = ~data_valid_d;
    if (data_valid_d) begin
      data_out_d = mux_byte_s;
    end else begin
      data_out_d = 8'h00;
    end
  end

  // Registered outputs, edge detector and overrun counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ovr_q        <= '0;
      sticky_q     <= 1'b0;
      data_ready_q <= 1'b0;
      data_valid_q <= 1'b0;
      rx_enable_q  <= 1'b1;
      idx_q        <= 4'd0;
      data_out_q   <= 8'h00;
    end else begin
      valid_q      <= bus.frame_valid;
      ovr_q        <= ovr_d;
      sticky_q     <= sticky_d;
      data_ready_q <= data_ready_d;
      data_valid_q <= data_valid_d;
      rx_enable_q  <= rx_enable_d;
      idx_q        <= idx_d;
      data_out_q   <= data_out_d;
    end
  end

  // Status is sampled before this cycle's increment, so a frame dropped at read start shows up next read.
  bep_snapshot_mux u_snapshot_mux (
    .clock         (clock),
    .reset         (reset),
    .load_snap_i   (load_snap_s),
    .snap_i        ({bus.state, bus.thermostat_id, bus.set_temp, bus.room_temp}),
    .load_status_i (freeze_s),
    .status_i      (make_status(ovr_q, sticky_q)),
    .index_i       (idx_d),
    .byte_o        (mux_byte_s)
  );

  assign bus.data_ready = data_ready_q;
  assign bus.data_valid = data_valid_q;
  assign bus.rx_enable  = rx_enable_q;
  assign bus.byte_index = idx_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_bep_readout_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-array reference model.
module tb_bep_readout_controller;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bep_readout_controller_if bus();

  bep_readout_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: snapshot as a byte array plus flags for "snapshot held" and "host reading".
  logic [7:0] m_bytes [9];
  bit         m_has, m_reading, m_fv_prev, m_sticky;
  int         m_idx, m_ovr;
  logic [7:0] m_frozen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_count_overrun();
    m_ovr    = (m_ovr < 15) ? m_ovr + 1 : 15;
    m_sticky = 1'b1;
  endtask

  task automatic model_store();
    logic [71:0] f;
    f = {bus.state, bus.thermostat_id, bus.set_temp, bus.room_temp};
    for (int i = 0; i < 9; i++) m_bytes[i] = f[i*8 +: 8];
  endtask

  task automatic model_step();
    bit cap;
    if (reset) begin
      m_has = 0; m_reading = 0; m_fv_prev = 0; m_sticky = 0;
      m_idx = 0; m_ovr = 0; m_frozen = 8'h00;
      for (int i = 0; i < 9; i++) m_bytes[i] = 8'h00;
    end else begin
      cap = bus.frame_valid && !m_fv_prev;
      m_fv_prev = bus.frame_valid;
      if (!m_has) begin
        if (cap) begin
          model_store();
          m_has = 1;
        end
      end else if (!m_reading) begin
        if (bus.read_start) begin
          m_frozen  = 8'((m_ovr << 4) | int'(m_sticky));
          m_reading = 1;
          m_idx     = 0;
          if (cap) model_count_overrun();
        end else if (cap) begin
          model_store();
          model_count_overrun();
        end
      end else begin
        if (cap) model_count_overrun();
        if (bus.read_abort) begin
          m_reading = 0;
          m_idx = 0;
        end else if (bus.byte_ack) begin
          if (m_idx == 9) begin
            m_reading = 0; m_has = 0; m_idx = 0; m_ovr = 0; m_sticky = 0;
          end else begin
            m_idx++;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_data;
    if (!m_reading) exp_data = 8'h00;
    else if (m_idx == 9) exp_data = m_frozen;
    else exp_data = m_bytes[m_idx];
    chk("data_ready", bus.data_ready, m_has);
    chk("data_valid", bus.data_valid, m_reading);
    chk("rx_enable", bus.rx_enable, !m_reading);
    chk("byte_index", bus.byte_index, m_idx);
    chk("data_out", bus.data_out, exp_data);
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later, strobes cleared.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
    bus.read_start = 1'b0;
    bus.byte_ack   = 1'b0;
    bus.read_abort = 1'b0;
  endtask

  task automatic frame(input logic [15:0] rt, input logic [15:0] st,
                       input logic [31:0] id, input logic [7:0] s);
    bus.room_temp = rt; bus.set_temp = st; bus.thermostat_id = id; bus.state = s;
    bus.frame_valid = 1'b1;
    cycle();
    bus.frame_valid = 1'b0;
    cycle();
  endtask

  task automatic acks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.byte_ack = 1'b1;
      cycle();
    end
  endtask

  logic [7:0] basic_exp [10];

  initial begin
    basic_exp = '{8'h34, 8'h12, 8'h56, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5A, 8'h00};
    reset = 1'b1;
    bus.frame_valid = 1'b0; bus.room_temp = 16'h0; bus.set_temp = 16'h0;
    bus.thermostat_id = 32'h0; bus.state = 8'h0;
    bus.read_start = 1'b0; bus.byte_ack = 1'b0; bus.read_abort = 1'b0;
    cycle(); cycle();
    chk("reset_rx_enable", bus.rx_enable, 1);
    chk("reset_data_ready", bus.data_ready, 0);
    reset = 1'b0;
    cycle();

    // Basic read
    frame(16'h1234, 16'h0456, 32'hDEADBEEF, 8'h5A);
    bus.read_start = 1'b1; cycle();
    for (int k = 0; k < 10; k++) begin
      chk("basic_byte", bus.data_out, basic_exp[k]);
      bus.byte_ack = 1'b1; cycle();
    end
    chk("basic_done_ready", bus.data_ready, 0);
    chk("basic_done_rx", bus.rx_enable, 1);

    // Overwrite of an unread snapshot
    frame(16'h1111, 16'h2222, 32'h33334444, 8'h55);
    frame(16'h00AA, 16'h0BBB, 32'h0CCC0DDD, 8'hEE);
    bus.read_start = 1'b1; cycle();
    chk("ovw_byte0", bus.data_out, 8'hAA);
    acks(9);
    chk("ovw_status", bus.data_out, 8'h11);
    acks(1);

    // Saturation: one capture into IDLE then 20 while READY
    for (int i = 0; i < 21; i++) frame(16'(i), 16'h0, 32'h0, 8'h0);
    bus.read_start = 1'b1; cycle();
    acks(9);
    chk("sat_status", bus.data_out, 8'hF1);
    acks(1);
    frame(16'h0777, 16'h0888, 32'h12345678, 8'h99);
    bus.read_start = 1'b1; cycle();
    acks(9);
    chk("sat_cleared_status", bus.data_out, 8'h00);
    acks(1);

    // Abort and restart
    frame(16'hBEEF, 16'h0101, 32'hCAFEF00D, 8'h3C);
    bus.read_start = 1'b1; cycle();
    acks(3);
    bus.read_abort = 1'b1; bus.byte_ack = 1'b1; cycle();
    chk("abort_ready", bus.data_ready, 1);
    chk("abort_valid", bus.data_valid, 0);
    bus.read_start = 1'b1; cycle();
    chk("restart_index", bus.byte_index, 0);
    chk("restart_byte0", bus.data_out, 8'hEF);
    acks(10);

    // Capture together with read_start while READY: old data read, count shows next read
    frame(16'h0042, 16'h0, 32'h0, 8'h0);
    bus.room_temp = 16'h0099; bus.frame_valid = 1'b1; bus.read_start = 1'b1; cycle();
    bus.frame_valid = 1'b0;
    chk("simul_old_byte0", bus.data_out, 8'h42);
    acks(9);
    chk("simul_status_now", bus.data_out, 8'h00);
    bus.read_abort = 1'b1; cycle();
    bus.read_start = 1'b1; cycle();
    acks(9);
    chk("simul_status_next", bus.data_out, 8'h11);
    acks(1);

    // Capture together with read_start in IDLE
    bus.room_temp = 16'h0013; bus.frame_valid = 1'b1; bus.read_start = 1'b1; cycle();
    bus.frame_valid = 1'b0;
    chk("idle_simul_ready", bus.data_ready, 1);
    chk("idle_simul_valid", bus.data_valid, 0);

    // Mid-read reset, then frame_valid already high at reset release
    bus.read_start = 1'b1; cycle();
    acks(5);
    chk("midreset_index_pre", bus.byte_index, 5);
    reset = 1'b1; bus.frame_valid = 1'b1; cycle();
    chk("midreset_rx", bus.rx_enable, 1);
    chk("midreset_valid", bus.data_valid, 0);
    chk("midreset_index", bus.byte_index, 0);
    reset = 1'b0; cycle();
    chk("release_capture", bus.data_ready, 1);
    bus.frame_valid = 1'b0; cycle();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.frame_valid = ~bus.frame_valid;
      bus.room_temp = 16'($urandom); bus.set_temp = 16'($urandom);
      bus.thermostat_id = $urandom; bus.state = 8'($urandom);
      bus.read_start = ($urandom_range(0, 7) == 0);
      bus.byte_ack   = ($urandom_range(0, 1) == 0);
      bus.read_abort = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 599) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
